hls_fp32_add_issue_ctrl: RTL and testbench

HLS_FP32_ADD_ISSUE_CTRL -- requirements
Module: hls_fp32_add_issue_ctrl

---
 rtl/hls_fp32_add_issue_ctrl.sv | 130 +++++++++++++
 tb/tb_hls_fp32_add_issue_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_fp32_add_issue_ctrl.sv
// ---------------------------------------------------------------------------
// hls_fp32_add_issue_ctrl
//
// Issue/flow controller for a fixed-latency fp32 add pipe that writes into
// a small output buffer. Operands A and B are joined: one add launches only
// when both are valid and a buffer slot is guaranteed. The guarantee comes
// from credit accounting rather than backpressure on the pipe. occ counts
// every add that has been launched but not yet popped, so it covers results
// still in the pipe as well as results already in the buffer. Because of
// this the pipe never has to stall.
//
// Ports
//   nvdla_core_clk   : clock, rising edge
//   nvdla_core_rst   : synchronous active-high reset
//   cfg_en           : enable issuing
//   flush_req        : stop issuing and drain what is in flight
//   flush_done       : one-cycle pulse when the drain completes
//   chn_a_vld/rdy    : operand A handshake (rdy == core_issue)
//   chn_b_vld/rdy    : operand B handshake (rdy == core_issue)
//   core_issue       : launch one add into pipe stage 0
//   core_wen         : pipe advance / clock-gate enable
//   pipe_vld[LAT]    : per-stage valid, bit LAT-1 is the final stage
//   ofifo_wr_en      : write final-stage result into the buffer
//   ofifo_wr_ptr     : buffer write address
//   ofifo_rd_ptr     : buffer read address
//   chn_o_vld/rdy    : result handshake toward downstream
//   busy             : not idle, or results still outstanding
// ---------------------------------------------------------------------------
module hls_fp32_add_issue_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          cfg_en,
    input  logic          flush_req,
    output logic          flush_done,
    input  logic          chn_a_vld,
    output logic          chn_a_rdy,
    input  logic          chn_b_vld,
    output logic          chn_b_rdy,
    output logic          core_issue,
    output logic          core_wen,
    output logic [LAT-1:0] pipe_vld,
    output logic          ofifo_wr_en,
    output logic [AW-1:0] ofifo_wr_ptr,
    output logic [AW-1:0] ofifo_rd_ptr,
    output logic          chn_o_vld,
    input  logic          chn_o_rdy,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t         state;
    logic [AW:0]    occ;
    logic [AW:0]    fcnt;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LAT-1:0] pipe_q;

    logic issue;
    logic wr;
    logic pop;

    // Credit is judged on the registered occ only, so a pop in the same
    // cycle frees its slot one cycle later. Every output is held low while
    // reset is asserted, because the state registers only clear at the edge.
    assign issue = !nvdla_core_rst && (state == RUN) && chn_a_vld && chn_b_vld
                   && (occ < DEPTH_C) && !flush_req && cfg_en;
    assign wr    = pipe_q[LAT-1];
    assign pop   = !nvdla_core_rst && (fcnt != '0) && chn_o_rdy;

    assign core_issue   = issue;
    assign chn_a_rdy    = issue;
    assign chn_b_rdy    = issue;
    assign core_wen     = issue || (!nvdla_core_rst && (|pipe_q));
    assign pipe_vld     = nvdla_core_rst ? '0 : pipe_q;
    assign ofifo_wr_en  = !nvdla_core_rst && wr;
    assign ofifo_wr_ptr = nvdla_core_rst ? '0 : wr_ptr;
    assign ofifo_rd_ptr = nvdla_core_rst ? '0 : rd_ptr;
    assign chn_o_vld    = !nvdla_core_rst && (fcnt != '0);
    assign busy         = !nvdla_core_rst && ((state != IDLE) || (occ != '0));
    // Asserted exactly in the cycle that DRAIN leaves for IDLE.
    assign flush_done   = !nvdla_core_rst && (state == DRAIN) && (occ == '0);

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state  <= IDLE;
            occ    <= '0;
            fcnt   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            pipe_q <= '0;
        end else begin
            // Fixed-latency valid shift; the pipe never stalls.
            pipe_q[0] <= issue;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end

            case (state)
                IDLE:    if (cfg_en && !flush_req) state <= RUN;
                RUN:     if (flush_req || !cfg_en) state <= DRAIN;
                DRAIN:   if (occ == '0)            state <= IDLE;
                default:                           state <= IDLE;
            endcase

            case ({issue, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            case ({wr, pop})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase

            // DEPTH is a power of two, so the natural AW-bit wrap is modulo DEPTH.
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_hls_fp32_add_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hls_fp32_add_issue_ctrl
//
// Directed bench for hls_fp32_add_issue_ctrl at LAT=4, DEPTH=4. Inputs
// change 1 time unit after a rising edge, and outputs are sampled 1 unit
// after that.
// ---------------------------------------------------------------------------
module tb_hls_fp32_add_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_en = 1'b0;
    logic       flush_req = 1'b0;
    logic       a_vld = 1'b0;
    logic       b_vld = 1'b0;
    logic       o_rdy = 1'b0;

    logic       flush_done, a_rdy, b_rdy, core_issue, core_wen;
    logic [3:0] pipe_vld;
    logic       wr_en;
    logic [1:0] wr_ptr, rd_ptr;
    logic       o_vld, busy;

    int errs   = 0;
    int checks = 0;

    logic [15:0] outs;
    assign outs = {flush_done, a_rdy, b_rdy, core_issue, core_wen, pipe_vld,
                   wr_en, wr_ptr, rd_ptr, o_vld, busy};

    hls_fp32_add_issue_ctrl #(.LAT(4), .DEPTH(4), .AW(2)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_en         (cfg_en),
        .flush_req      (flush_req),
        .flush_done     (flush_done),
        .chn_a_vld      (a_vld),
        .chn_a_rdy      (a_rdy),
        .chn_b_vld      (b_vld),
        .chn_b_rdy      (b_rdy),
        .core_issue     (core_issue),
        .core_wen       (core_wen),
        .pipe_vld       (pipe_vld),
        .ofifo_wr_en    (wr_en),
        .ofifo_wr_ptr   (wr_ptr),
        .ofifo_rd_ptr   (rd_ptr),
        .chn_o_vld      (o_vld),
        .chn_o_rdy      (o_rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two reset edges; on return the current cycle is the first IDLE cycle.
    task automatic do_reset();
        rst = 1'b1; cfg_en = 1'b0; flush_req = 1'b0;
        a_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
        tick();
        tick();
        #1;
        checks++;
        if (outs !== 16'h0) begin
            errs++; $display("FAIL reset_held: outs=%h expected %h", outs, 16'h0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 16'h0) begin
            errs++; $display("FAIL reset_first_idle: outs=%h expected %h", outs, 16'h0);
        end
        tick();
        #1;
        checks++;
        if (core_issue !== 1'b1) begin
            errs++; $display("FAIL run_first_issue: core_issue=%b expected 1", core_issue);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 16'h0) begin
            errs++; $display("FAIL reset_mid_run: outs=%h expected %h", outs, 16'h0);
        end
    endtask

    task automatic test_stream();
        // Per-cycle expectations, MSB = first RUN cycle (k=0).
        logic [11:0] e_iss, e_wr, e_vld;
        logic [5:0]  got, exp;
        e_iss = 12'b1111_0011_1100;
        e_wr  = 12'b0000_1111_0011;
        e_vld = 12'b0000_0111_1001;
        do_reset();
        cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
        #1;
        checks++;
        if ({core_issue, busy} !== 2'b00) begin
            errs++; $display("FAIL stream_idle: issue,busy=%b expected 00", {core_issue, busy});
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            #1;
            got = {core_issue, a_rdy, b_rdy, core_wen, wr_en, o_vld};
            exp = {e_iss[11-k], e_iss[11-k], e_iss[11-k], 1'b1, e_wr[11-k], e_vld[11-k]};
            checks++;
            if (got !== exp) begin
                errs++; $display("FAIL stream_k%0d: iss,ardy,brdy,wen,wr,ovld=%b expected %b", k, got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        do_reset();
        cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            #1;
            if (core_issue) n++;
        end
        checks++;
        if (n !== 4) begin
            errs++; $display("FAIL bp_issue_count: got %0d expected 4", n);
        end
        checks++;
        if ({a_rdy, o_vld, busy, wr_ptr, rd_ptr} !== 7'b0_1_1_00_00) begin
            errs++; $display("FAIL bp_full: ardy,ovld,busy,wptr,rptr=%b expected 0110000",
                             {a_rdy, o_vld, busy, wr_ptr, rd_ptr});
        end
        o_rdy = 1'b1;
        #1;
        checks++;
        if ({core_issue, o_vld} !== 2'b01) begin
            errs++; $display("FAIL bp_pop_no_credit: issue,ovld=%b expected 01", {core_issue, o_vld});
        end
        tick();
        #1;
        checks++;
        if ({core_issue, rd_ptr} !== 3'b1_01) begin
            errs++; $display("FAIL bp_issue_after_pop: issue,rptr=%b expected 101", {core_issue, rd_ptr});
        end
    endtask

    task automatic test_join();
        do_reset();
        cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b0; o_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            #1;
            checks++;
            if ({core_issue, a_rdy, b_rdy} !== 3'b000) begin
                errs++; $display("FAIL join_a_only_k%0d: issue,ardy,brdy=%b expected 000",
                                 k, {core_issue, a_rdy, b_rdy});
            end
        end
        b_vld = 1'b1;
        #1;
        checks++;
        if ({core_issue, a_rdy, b_rdy} !== 3'b111) begin
            errs++; $display("FAIL join_both: issue,ardy,brdy=%b expected 111", {core_issue, a_rdy, b_rdy});
        end
    endtask

    task automatic test_flush();
        int pops, fds, fd_k, iss;
        pops = 0; fds = 0; fd_k = -1; iss = 0;
        do_reset();
        cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checks++;
            if (core_issue !== 1'b1) begin
                errs++; $display("FAIL flush_pre_issue_k%0d: issue=%b expected 1", k, core_issue);
            end
        end
        tick();
        flush_req = 1'b1;
        #1;
        checks++;
        if (core_issue !== 1'b0) begin
            errs++; $display("FAIL flush_stop_same_cycle: issue=%b expected 0", core_issue);
        end
        for (int k = 4; k < 13; k++) begin
            tick();
            #1;
            if (o_vld && o_rdy) pops++;
            if (core_issue) iss++;
            if (flush_done) begin
                fds++;
                fd_k = k;
            end
        end
        checks++;
        if (pops !== 3) begin
            errs++; $display("FAIL flush_pops: got %0d expected 3", pops);
        end
        checks++;
        if (fds !== 1 || fd_k !== 8) begin
            errs++; $display("FAIL flush_done_pulse: count=%0d at k=%0d expected 1 at k=8", fds, fd_k);
        end
        checks++;
        if (iss !== 0 || busy !== 1'b0) begin
            errs++; $display("FAIL flush_idle: issues=%0d busy=%b expected 0 and 0", iss, busy);
        end
    endtask

    task automatic test_wrap_and_reset();
        int iss, pops, wrs, rwrap, wwrap, n;
        bit done;
        iss = 0; pops = 0; wrs = 0; rwrap = 0; wwrap = 0; n = 0; done = 1'b0;
        do_reset();
        cfg_en = 1'b1; a_vld = 1'b1; b_vld = 1'b1; o_rdy = 1'b1;
        for (int k = 0; k < 80 && !done; k++) begin
            tick();
            if (iss >= 9) cfg_en = 1'b0;
            #1;
            if (core_issue) iss++;
            if (wr_en) begin
                checks++;
                if (wr_ptr !== 2'(wrs % 4)) begin
                    errs++; $display("FAIL wrap_wr_ptr_%0d: got %0d expected %0d", wrs, wr_ptr, wrs % 4);
                end
                if (wr_ptr == 2'd3) wwrap++;
                wrs++;
            end
            if (o_vld && o_rdy) begin
                checks++;
                if (rd_ptr !== 2'(pops % 4)) begin
                    errs++; $display("FAIL wrap_rd_ptr_%0d: got %0d expected %0d", pops, rd_ptr, pops % 4);
                end
                if (rd_ptr == 2'd3) rwrap++;
                pops++;
            end
            if (iss >= 9 && !busy) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errs++; $display("FAIL wrap_timeout: issues=%0d pops=%0d busy=%b expected idle", iss, pops, busy);
        end
        checks++;
        if (iss !== 9 || pops !== 9 || wrs !== 9) begin
            errs++; $display("FAIL wrap_counts: iss=%0d wr=%0d pop=%0d expected 9 9 9", iss, wrs, pops);
        end
        checks++;
        if (rwrap !== 2 || wwrap !== 2 || rd_ptr !== 2'd1 || wr_ptr !== 2'd1) begin
            errs++; $display("FAIL wrap_pointers: rwrap=%0d wwrap=%0d rptr=%0d wptr=%0d expected 2 2 1 1",
                             rwrap, wwrap, rd_ptr, wr_ptr);
        end

        // Two results outstanding, then reset with nothing popped.
        o_rdy = 1'b0; cfg_en = 1'b1;
        for (int k = 0; k < 10 && n < 2; k++) begin
            tick();
            #1;
            if (core_issue) n++;
        end
        tick();
        cfg_en = 1'b0;
        tick();
        tick();
        tick();
        #1;
        checks++;
        if ({n[1:0], busy, o_vld, flush_done} !== 5'b10_1_1_0) begin
            errs++; $display("FAIL occ2_before_reset: n=%0d busy=%b ovld=%b fdone=%b expected 2 1 1 0",
                             n, busy, o_vld, flush_done);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 16'h0) begin
            errs++; $display("FAIL occ2_reset_asserted: outs=%h expected %h", outs, 16'h0);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (outs !== 16'h0) begin
                errs++; $display("FAIL occ2_after_reset_k%0d: outs=%h expected %h", k, outs, 16'h0);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_join();
        test_flush();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
